// File: rtl/calc_display_ctrl.sv
// Display-source controller: operand A/B, live result or browsed history entry to the display driver.
// Optional overflow blink is built only when CALC_DISP_BLINK_EN is defined.
module calc_display_ctrl #(
  parameter int WIDTH = 40,
  parameter int N_OPS = 8,
  parameter int OP_W  = 3,
  parameter int DEPTH = 4
`ifdef CALC_DISP_BLINK_EN
  , parameter int BLINK_DIV = 25000000
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                estado,
  input  logic [OP_W-1:0]           op,
  input  logic [WIDTH-1:0]          reg_a,
  input  logic [WIDTH-1:0]          reg_b,
  input  logic [N_OPS*WIDTH-1:0]    res_bus,
  input  logic [N_OPS-1:0]          res_done,
  input  logic [N_OPS-1:0]          res_ovf,
  input  logic                      hist_prev,
  input  logic                      hist_next,
  output logic [WIDTH-1:0]          disp,
  output logic [1:0]                disp_src,
  output logic                      ovf,
  output logic [$clog2(DEPTH):0]    hist_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int N_SLOT = 2**OP_W;

  typedef enum logic [2:0] {S_A, S_B, S_WAIT, S_RES, S_HIST} state_t;

  state_t               state;
  logic [WIDTH-1:0]     word_q;
  logic [WIDTH-1:0]     res_word;
  logic                 res_ovf_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     offset;
  logic [WIDTH:0]       hist_mem [DEPTH];

  // Zero-padding to 2**OP_W slots makes out-of-range op codes read as "never done".
  logic [N_SLOT*WIDTH-1:0] bus_pad;
  logic [N_SLOT-1:0]       done_pad;
  logic [N_SLOT-1:0]       ovf_pad;
  logic [WIDTH-1:0]        sel_word;
  logic                    sel_ovf;

  assign bus_pad  = (N_SLOT*WIDTH)'(res_bus);
  assign done_pad = N_SLOT'(res_done);
  assign ovf_pad  = N_SLOT'(res_ovf);
  assign sel_word = bus_pad[int'(op)*WIDTH +: WIDTH];
  assign sel_ovf  = ovf_pad[op];

  function automatic logic [PTR_W-1:0] ent_idx(input logic [PTR_W-1:0] wp,
                                               input logic [CNT_W-1:0] off);
    int i;
    i = (int'(wp) + 4*DEPTH - 1 - int'(off)) % DEPTH;
    return PTR_W'(i);
  endfunction

  logic           computing;
  logic           cap_hit;
  logic           prev_step;
  logic           next_step;
  logic [WIDTH:0] prev_ent;
  logic [WIDTH:0] next_ent;

  assign computing = (estado == 2'b11);
  assign cap_hit   = computing && (state == S_WAIT) && done_pad[op];
  assign prev_step = computing && hist_prev && !hist_next &&
                     (((state == S_RES) && (hist_cnt >= CNT_W'(2))) ||
                      ((state == S_HIST) && (offset < hist_cnt - CNT_W'(1))));
  assign next_step = computing && hist_next && !hist_prev && (state == S_HIST);
  assign prev_ent  = hist_mem[ent_idx(wr_ptr, offset + CNT_W'(1))];
  assign next_ent  = hist_mem[ent_idx(wr_ptr, offset - CNT_W'(1))];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      word_q    <= '0;
      disp_src  <= 2'd0;
      ovf       <= 1'b0;
      hist_cnt  <= '0;
      wr_ptr    <= '0;
      offset    <= '0;
      res_word  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      case (estado)
        2'b01: begin
          state    <= S_A;
          word_q   <= reg_a;
          disp_src <= 2'd0;
          ovf      <= 1'b0;
          offset   <= '0;
        end
        2'b10: begin
          state    <= S_B;
          word_q   <= reg_b;
          disp_src <= 2'd1;
          ovf      <= 1'b0;
          offset   <= '0;
        end
        2'b11: begin
          if (state == S_A || state == S_B) begin
            state <= S_WAIT;
          end else if (cap_hit) begin
            res_word         <= sel_word;
            res_ovf_q        <= sel_ovf;
            hist_mem[wr_ptr] <= {sel_ovf, sel_word};
            wr_ptr           <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
            if (hist_cnt != CNT_W'(DEPTH)) hist_cnt <= hist_cnt + CNT_W'(1);
            word_q   <= sel_word;
            ovf      <= sel_ovf;
            disp_src <= 2'd2;
            offset   <= '0;
            state    <= S_RES;
          end else if (prev_step) begin
            state    <= S_HIST;
            offset   <= offset + CNT_W'(1);
            word_q   <= prev_ent[WIDTH-1:0];
            ovf      <= prev_ent[WIDTH];
            disp_src <= 2'd3;
          end else if (next_step) begin
            if (offset == CNT_W'(1)) begin
              // Stepping past the newest stored entry lands back on the live result.
              state    <= S_RES;
              offset   <= '0;
              word_q   <= res_word;
              ovf      <= res_ovf_q;
              disp_src <= 2'd2;
            end else begin
              offset   <= offset - CNT_W'(1);
              word_q   <= next_ent[WIDTH-1:0];
              ovf      <= next_ent[WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blank;

  // Any capture, browse step or leaving result display restarts the blink with the entry visible.
  always_ff @(posedge clk) begin
    if (rst || cap_hit || prev_step || next_step || !ovf || !disp_src[1] ||
        estado == 2'b01 || estado == 2'b10) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV-1)) begin
      blink_cnt <= '0;
      blank     <= ~blank;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign disp = (blank && ovf && disp_src[1]) ? '0 : word_q;
`else
  assign disp = word_q;
`endif

endmodule
